// File: rtl/latency_sched_pkg.sv
// Shared defaults and helpers for the delayed-event scheduler.
package latency_sched_pkg;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned NSLOT_DEF = 4;
  localparam int unsigned DSIZE_DEF = 12;
  localparam int unsigned CSIZE_DEF = 5;

  // A zero latency would expire before it could be seen, so it behaves as one cycle.
  function automatic logic [31:0] lat_min1(input logic [31:0] lat);
    return (lat == '0) ? 32'd1 : lat;
  endfunction

endpackage

// File: rtl/latency_sched_rr_arbiter.sv
// Round-robin single-grant arbiter; the pointer advances past each accepted winner.
module sched_rr_arbiter
  import latency_sched_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF
) (
  input  logic            clock,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            enable,
  output logic [NREQ-1:0] gnt
);

  localparam int unsigned PW = $clog2(NREQ);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] scan_idx;

  always_comb begin
    gnt      = '0;
    ptr_d    = ptr_q;
    scan_idx = '0;
    if (enable) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        scan_idx = PW'((32'(ptr_q) + k) % NREQ);
        if (req[scan_idx] && (gnt == '0)) begin
          gnt[scan_idx] = 1'b1;
          ptr_d         = PW'((32'(scan_idx) + 32'd1) % NREQ);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/latency_sched.sv
// Shared pool of countdown slots issuing one-cycle done pulses a programmed delay after accept.
module latency_sched
  import latency_sched_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned NSLOT = NSLOT_DEF,
  parameter int unsigned DSIZE = DSIZE_DEF,
  parameter int unsigned CSIZE = CSIZE_DEF
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] req_lat,
  output logic [NREQ-1:0]       gnt,
  input  logic                  flush,
  output logic [NREQ-1:0]       done,
  output logic [NREQ-1:0]       overrun,
  output logic [CSIZE-1:0]      occupancy,
  output logic                  full
);

  localparam int unsigned OW = $clog2(NREQ);
  localparam int unsigned SW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  logic [NSLOT-1:0] slot_valid;
  logic [NSLOT-1:0] slot_exp;
  logic [OW-1:0]    slot_owner [NSLOT];

  logic             arb_en;
  logic             accept;
  logic [OW-1:0]    win_idx;
  logic [DSIZE-1:0] win_lat;
  logic [DSIZE-1:0] load_lat;
  logic [SW-1:0]    alloc_idx;
  logic             alloc_found;

  logic [CSIZE-1:0] occ_d, occ_q;
  logic             full_d, full_q;

  // Free-slot status comes from registered valid bits only, so a slot freed
  // at an edge is offered again from the following cycle.
  assign arb_en = rst_n && !flush && !(&slot_valid);

  sched_rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .clock (clock),
    .rst_n (rst_n),
    .req   (req),
    .enable(arb_en),
    .gnt   (gnt)
  );

  assign accept = |gnt;

  always_comb begin
    win_idx = '0;
    win_lat = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win_idx = OW'(i);
        win_lat = req_lat[i*DSIZE +: DSIZE];
      end
    end
  end

  assign load_lat = DSIZE'(lat_min1(32'(win_lat)));

  always_comb begin
    alloc_idx   = '0;
    alloc_found = 1'b0;
    for (int unsigned s = 0; s < NSLOT; s++) begin
      if (!slot_valid[s] && !alloc_found) begin
        alloc_idx   = SW'(s);
        alloc_found = 1'b1;
      end
    end
  end

  for (genvar s = 0; s < NSLOT; s++) begin : g_slot
    logic             valid_q;
    logic [OW-1:0]    owner_q;
    logic [DSIZE-1:0] cnt_q;
    logic             load;

    assign load = accept && alloc_found && (alloc_idx == SW'(s));

    // Counter holds the remaining edges until expiry; the expiring edge both
    // frees the slot and registers the done pulse.
    always_ff @(posedge clock) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        owner_q <= '0;
        cnt_q   <= '0;
      end else if (flush) begin
        valid_q <= 1'b0;
      end else if (load) begin
        valid_q <= 1'b1;
        owner_q <= win_idx;
        cnt_q   <= load_lat;
      end else if (valid_q) begin
        if (cnt_q == DSIZE'(1)) begin
          valid_q <= 1'b0;
        end else begin
          cnt_q <= cnt_q - DSIZE'(1);
        end
      end
    end

    assign slot_valid[s] = valid_q;
    assign slot_owner[s] = owner_q;
    assign slot_exp[s]   = valid_q && (cnt_q == DSIZE'(1));
  end

  for (genvar r = 0; r < NREQ; r++) begin : g_req
    logic [NSLOT-1:0] hit;
    logic             done_q;
    logic             ovr_q;

    always_comb begin
      hit = '0;
      for (int unsigned s = 0; s < NSLOT; s++) begin
        hit[s] = slot_exp[s] && (slot_owner[s] == OW'(r));
      end
    end

    always_ff @(posedge clock) begin
      if (!rst_n) begin
        done_q <= 1'b0;
        ovr_q  <= 1'b0;
      end else begin
        done_q <= !flush && (|hit);
        if (!flush && ((hit & (hit - NSLOT'(1))) != '0)) begin
          ovr_q <= 1'b1;
        end
      end
    end

    assign done[r]    = done_q;
    assign overrun[r] = ovr_q;
  end

  always_comb begin
    occ_d = '0;
    for (int unsigned s = 0; s < NSLOT; s++) begin
      occ_d = occ_d + CSIZE'(slot_valid[s]);
    end
    full_d = (occ_d == CSIZE'(NSLOT));
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      occ_q  <= '0;
      full_q <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      full_q <= full_d;
    end
  end

  assign occupancy = occ_q;
  assign full      = full_q;

endmodule

// File: tb/tb_latency_sched.sv
// Randomized scoreboard bench for latency_sched against an event-list reference model.
module tb_latency_sched;

  localparam int NREQ  = 4;
  localparam int NSLOT = 4;
  localparam int DSIZE = 12;
  localparam int CSIZE = 5;

  logic                  clock = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  flush = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*DSIZE-1:0] req_lat = '0;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [NREQ-1:0]       overrun;
  logic [CSIZE-1:0]      occupancy;
  logic                  full;

  always #5 clock = ~clock;

  latency_sched #(
    .NREQ (NREQ),
    .NSLOT(NSLOT),
    .DSIZE(DSIZE),
    .CSIZE(CSIZE)
  ) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .req      (req),
    .req_lat  (req_lat),
    .gnt      (gnt),
    .flush    (flush),
    .done     (done),
    .overrun  (overrun),
    .occupancy(occupancy),
    .full     (full)
  );

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  always @(posedge clock) edge_n <= edge_n + 1;

  typedef struct {int due; int owner;} ev_t;
  typedef struct {int e_idx; int occ;} occ_t;

  ev_t             exp_q[$];
  occ_t            occ_q[$];
  int              live[$];
  int              ptr_m    = 0;
  int              rst_edge = -1;
  logic [NREQ-1:0] acc_vec  = '0;
  logic [NREQ-1:0] pend     = '0;
  int              lat[NREQ];

  // Reference model: each in-flight event is just its due edge; arbitration
  // is a rotating search over requesters while fewer than NSLOT are live.
  initial begin : model
    int n, w, win, L;
    logic [NREQ-1:0] eg;
    forever begin
      @(negedge clock);
      n = edge_n;
      for (int k = live.size() - 1; k >= 0; k--)
        if (live[k] <= n) live.delete(k);
      eg  = '0;
      win = 0;
      if (rst_n && !flush && (live.size() < NSLOT)) begin
        for (int k = 0; k < NREQ; k++) begin
          w = (ptr_m + k) % NREQ;
          if (req[w] && (eg == '0)) begin
            eg[w] = 1'b1;
            win   = w;
          end
        end
      end
      if (rst_n) begin
        checks++;
        if (gnt !== eg) begin
          failures++;
          $display("FAIL gnt edge=%0d got=%b expected=%b", n, gnt, eg);
        end
      end
      if (!rst_n) begin
        live.delete();
        exp_q.delete();
        ptr_m    = 0;
        rst_edge = n + 1;
        acc_vec  = '0;
        occ_q.push_back('{n + 1, 0});
      end else begin
        occ_q.push_back('{n + 1, live.size()});
        if (flush) begin
          live.delete();
          exp_q.delete();
          acc_vec = '0;
        end else begin
          acc_vec = eg;
          if (eg != '0) begin
            L = (lat[win] == 0) ? 1 : lat[win];
            live.push_back(n + 1 + L);
            exp_q.push_back('{n + 1 + L, win});
            ptr_m = (win + 1) % NREQ;
          end
        end
      end
    end
  end

  initial begin : monitor
    int m;
    int cnt[NREQ];
    logic [NREQ-1:0] ed;
    logic [NREQ-1:0] ovr_m;
    occ_t o;
    ovr_m = '0;
    forever begin
      @(posedge clock);
      #2;
      m = edge_n;
      if (m == rst_edge) ovr_m = '0;
      for (int r = 0; r < NREQ; r++) cnt[r] = 0;
      for (int k = exp_q.size() - 1; k >= 0; k--) begin
        if (exp_q[k].due == m) begin
          cnt[exp_q[k].owner]++;
          exp_q.delete(k);
        end
      end
      ed = '0;
      for (int r = 0; r < NREQ; r++) begin
        ed[r] = (cnt[r] > 0);
        if (cnt[r] > 1) ovr_m[r] = 1'b1;
      end
      checks++;
      if (done !== ed) begin
        failures++;
        $display("FAIL done edge=%0d got=%b expected=%b", m, done, ed);
      end
      checks++;
      if (overrun !== ovr_m) begin
        failures++;
        $display("FAIL overrun edge=%0d got=%b expected=%b", m, overrun, ovr_m);
      end
      if ((occ_q.size() > 0) && (occ_q[0].e_idx == m)) begin
        o = occ_q.pop_front();
        checks++;
        if (occupancy !== CSIZE'(o.occ)) begin
          failures++;
          $display("FAIL occupancy edge=%0d got=%0d expected=%0d", m, occupancy, o.occ);
        end
        checks++;
        if (full !== (o.occ == NSLOT)) begin
          failures++;
          $display("FAIL full edge=%0d got=%b expected=%b", m, full, (o.occ == NSLOT));
        end
      end
    end
  end

  task automatic drive();
    req = pend;
    for (int i = 0; i < NREQ; i++) req_lat[i*DSIZE +: DSIZE] = DSIZE'(lat[i]);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    pend = pend & ~acc_vec;
    drive();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic request(input int i, input int L);
    bit ok;
    ok     = 1'b0;
    lat[i] = L;
    pend[i] = 1'b1;
    drive();
    for (int k = 0; k < 5000; k++) begin
      step();
      if (!pend[i]) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept req=%0d got=pending expected=granted", i);
      pend[i] = 1'b0;
      drive();
    end
  endtask

  initial begin : stim
    for (int i = 0; i < NREQ; i++) lat[i] = 0;
    step();
    step();
    rst_n = 1'b1;

    request(0, 5);
    idle(10);

    for (int i = 0; i < NREQ; i++) lat[i] = 100;
    pend = '1;
    drive();
    idle(8);
    request(0, 3);
    idle(110);

    request(1, 6);
    request(1, 5);
    idle(10);

    request(2, 0);
    idle(4);

    request(3, 4095);
    idle(4100);

    request(0, 30);
    request(1, 30);
    request(2, 30);
    idle(3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle(40);

    request(1, 6);
    request(1, 5);
    request(3, 30);
    idle(3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle(40);

    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            pend[i] = 1'b1;
            lat[i]  = ($urandom_range(0, 49) == 0) ? int'($urandom_range(0, 400))
                                                   : int'($urandom_range(0, 12));
          end
        end else if ($urandom_range(0, 40) == 0) begin
          pend[i] = 1'b0;
        end
      end
      flush = ($urandom_range(0, 99) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      drive();
      step();
    end
    flush = 1'b0;
    rst_n = 1'b1;
    pend  = '0;
    drive();
    idle(500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
